// File: rtl/avalon_master_arbiter_pkg.sv
// Shared types and helpers for the Avalon-MM master arbiter slice.
// Holds the FSM state encoding, the arbitration mode constants and width helpers.
package avalon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

    // Index width never collapses to zero so single-port builds still elaborate.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avalon_master_arbiter_if.sv
// Avalon-MM master port bundle. The arbiter drives the master modport;
// the slave modport is what the attached fabric or memory model sees.
interface avalon_master_arbiter_if
    import avalon_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0]             address;
    logic                          read;
    logic                          write;
    logic                          waitrequest;
    logic [DATA_W-1:0]             writedata;
    logic [byte_lanes(DATA_W)-1:0] byteenable;
    logic [DATA_W-1:0]             readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        output byteenable,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        input  byteenable,
        output waitrequest,
        output readdata
    );

endinterface

// File: rtl/avalon_master_arbiter_rr_arbiter.sv
// Combinational winner select over the request vector.
// Fixed mode picks the lowest set index; round-robin scans upward from rr_ptr with wrap.
module rr_arbiter
    import avalon_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ARB_MODE  = ARB_FIXED,
    localparam int IDX_W    = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     rr_ptr_i,
    output logic                 gnt_valid_o,
    output logic [IDX_W-1:0]     gnt_idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win;

    always_comb begin
        found = 1'b0;
        cand  = '0;
        win   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == ARB_RR) begin
                cand = IDX_W'((int'(rr_ptr_i) + k) % NUM_PORTS);
            end else begin
                cand = IDX_W'(k);
            end
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign gnt_valid_o = found;
    assign gnt_idx_o   = win;

endmodule

// File: rtl/avalon_master_arbiter.sv
// Avalon-MM master front-end: arbitrates NUM_PORTS requesters onto one master port,
// one transaction outstanding, optional waitrequest timeout that completes with an error.
//   state | meaning
//   IDLE  | waiting for any req_valid; arbitrates and latches the winner
//   BUS   | strobe asserted, waiting for waitrequest low or timeout
//   DONE  | resp_valid pulse to the granted port; no arbitration here
module avalon_master_arbiter
    import avalon_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = ARB_FIXED,
    parameter int TIMEOUT   = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_PORTS-1:0]                   req_valid_i,
    input  logic [NUM_PORTS-1:0]                   req_write_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]            req_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]            req_wdata_i,
    input  logic [NUM_PORTS*byte_lanes(DATA_W)-1:0] req_be_i,
    output logic [NUM_PORTS-1:0]                   resp_valid_o,
    output logic [DATA_W-1:0]                      resp_rdata_o,
    output logic                                   resp_error_o,
    output logic                                   busy_o,
    avalon_master_arbiter_if.master                av
);

    localparam int BE_W  = byte_lanes(DATA_W);
    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam int LSB   = $clog2(BE_W);
    localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [ADDR_W-1:0]    ADDR_MASK = ~ADDR_W'((64'd1 << LSB) - 64'd1);
    localparam logic [TO_W-1:0]      TO_LAST   = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [NUM_PORTS-1:0] ONE_HOT   = NUM_PORTS'(1);

    arb_state_t            state_q;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      rr_ptr_q;
    logic [IDX_W-1:0]      rr_ptr_d;
    logic [TO_W-1:0]       to_cnt_q;
    logic [ADDR_W-1:0]     address_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [BE_W-1:0]       be_q;
    logic                  read_q;
    logic                  write_q;
    logic [NUM_PORTS-1:0]  resp_valid_q;
    logic [DATA_W-1:0]     resp_rdata_q;
    logic                  resp_error_q;

    logic                  gnt_valid;
    logic [IDX_W-1:0]      gnt_idx;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic [BE_W-1:0]       sel_be;
    logic                  sel_write;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  (ARB_MODE)
    ) u_arb (
        .req_i       (req_valid_i),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
                sel_be    = req_be_i[i*BE_W +: BE_W];
                sel_write = req_write_i[i];
            end
        end
    end

    always_comb begin
        if (gnt_idx == IDX_W'(NUM_PORTS - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            to_cnt_q     <= '0;
            address_q    <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            resp_valid_q <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            resp_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        grant_q   <= gnt_idx;
                        rr_ptr_q  <= rr_ptr_d;
                        address_q <= sel_addr & ADDR_MASK;
                        wdata_q   <= sel_wdata;
                        be_q      <= sel_be;
                        // A write with no enabled lanes has nothing to put on the bus.
                        if (sel_write && (sel_be == '0)) begin
                            state_q      <= DONE;
                            resp_valid_q <= ONE_HOT << gnt_idx;
                        end else begin
                            state_q  <= BUS;
                            read_q   <= ~sel_write;
                            write_q  <= sel_write;
                            to_cnt_q <= '0;
                        end
                    end
                end
                BUS: begin
                    if (!av.waitrequest) begin
                        read_q       <= 1'b0;
                        write_q      <= 1'b0;
                        state_q      <= DONE;
                        resp_valid_q <= ONE_HOT << grant_q;
                        if (read_q) begin
                            resp_rdata_q <= av.readdata;
                        end
                    end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
                        read_q       <= 1'b0;
                        write_q      <= 1'b0;
                        state_q      <= DONE;
                        resp_valid_q <= ONE_HOT << grant_q;
                        resp_error_q <= 1'b1;
                        resp_rdata_q <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign av.address    = address_q;
    assign av.read       = read_q;
    assign av.write      = write_q;
    assign av.writedata  = wdata_q;
    assign av.byteenable = be_q;

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_error_o = resp_error_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// Directed bench: a round-robin/timeout build and a fixed-priority build share
// the request and bus-response stimulus; outputs are checked on falling edges.
module tb_avalon_master_arbiter;
    import avalon_pkg::*;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_write;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [NP*BW-1:0] req_be;
    logic             waitrequest;
    logic [DW-1:0]    readdata;

    logic [NP-1:0] rv_rr, rv_fx;
    logic [DW-1:0] rd_rr, rd_fx;
    logic          er_rr, er_fx, busy_rr, busy_fx;

    avalon_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_rr ();
    avalon_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_fx ();

    assign bus_rr.waitrequest = waitrequest;
    assign bus_rr.readdata    = readdata;
    assign bus_fx.waitrequest = waitrequest;
    assign bus_fx.readdata    = readdata;

    avalon_master_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(ARB_RR), .TIMEOUT(8)
    ) dut_rr (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(rv_rr), .resp_rdata_o(rd_rr), .resp_error_o(er_rr), .busy_o(busy_rr),
        .av(bus_rr)
    );

    avalon_master_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(ARB_FIXED), .TIMEOUT(0)
    ) dut_fx (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(rv_fx), .resp_rdata_o(rd_fx), .resp_error_o(er_fx), .busy_o(busy_fx),
        .av(bus_fx)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_write[p]          = wr;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = d;
        req_be[p*BW +: BW]    = be;
    endtask

    initial begin
        req_valid   = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        waitrequest = 1'b0;
        readdata    = 32'hDEADBEEF;
        reset       = 1'b1;
        tick();
        tick();

        chk("rst_read",   bus_rr.read, 0);
        chk("rst_write",  bus_rr.write, 0);
        chk("rst_rv",     rv_rr, 0);
        chk("rst_err",    er_rr, 0);
        chk("rst_busy",   busy_rr, 0);
        chk("rst_addr",   bus_rr.address, 0);
        chk("rst_wdata",  bus_rr.writedata, 0);
        chk("rst_be",     bus_rr.byteenable, 0);
        chk("rst_rdata",  rd_rr, 0);
        chk("rst_fx_read", bus_fx.read, 0);
        reset = 1'b0;

        // single read, zero wait states
        set_req(0, 1'b0, 32'h0000_1004, 32'h0, 4'hF);
        req_valid = 2'b01;
        tick();
        chk("rd_read",    bus_rr.read, 1);
        chk("rd_write",   bus_rr.write, 0);
        chk("rd_addr",    bus_rr.address, 32'h1004);
        chk("rd_busy",    busy_rr, 1);
        chk("rd_rv_early", rv_rr, 0);
        chk("rd_fx_addr", bus_fx.address, 32'h1004);
        tick();
        chk("rd_read_off", bus_rr.read, 0);
        chk("rd_rv",      rv_rr, 2'b01);
        chk("rd_rdata",   rd_rr, 32'hDEADBEEF);
        chk("rd_err",     er_rr, 0);
        chk("rd_fx_rv",   rv_fx, 2'b01);
        chk("rd_fx_rdata", rd_fx, 32'hDEADBEEF);
        req_valid = 2'b00;
        tick();
        chk("rd_rv_off",  rv_rr, 0);
        chk("rd_idle",    busy_rr, 0);

        // write from port 1 with four wait states; request changes mid-transfer are ignored
        set_req(1, 1'b1, 32'h0000_0013, 32'h1234_5678, 4'b0100);
        req_valid   = 2'b10;
        waitrequest = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("wr_write_%0d", k), bus_rr.write, 1);
            chk($sformatf("wr_read_%0d", k),  bus_rr.read, 0);
            chk($sformatf("wr_addr_%0d", k),  bus_rr.address, 32'h10);
            chk($sformatf("wr_be_%0d", k),    bus_rr.byteenable, 4'b0100);
            chk($sformatf("wr_wdata_%0d", k), bus_rr.writedata, 32'h1234_5678);
            chk($sformatf("wr_rv_%0d", k),    rv_rr, 0);
            chk($sformatf("wr_fx_addr_%0d", k), bus_fx.address, 32'h10);
            if (k == 2) set_req(1, 1'b1, 32'h0000_0FF0, 32'h0, 4'hF);
            if (k == 5) waitrequest = 1'b0;
        end
        tick();
        chk("wr_write_off", bus_rr.write, 0);
        chk("wr_rv",      rv_rr, 2'b10);
        chk("wr_err",     er_rr, 0);
        chk("wr_fx_rv",   rv_fx, 2'b10);
        req_valid = 2'b00;
        tick();
        chk("wr_rv_off",  rv_rr, 0);

        // both ports held: round-robin alternates, fixed priority keeps port 0
        readdata = 32'hCAFE_0000;
        set_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk($sformatf("arb_rr_addr_%0d", t), bus_rr.address, (t % 2 == 0) ? 32'h100 : 32'h200);
            chk($sformatf("arb_fx_addr_%0d", t), bus_fx.address, 32'h100);
            tick();
            chk($sformatf("arb_rr_rv_%0d", t), rv_rr, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("arb_fx_rv_%0d", t), rv_fx, 2'b01);
            chk($sformatf("arb_rr_rdata_%0d", t), rd_rr, 32'hCAFE_0000);
            if (t == 3) req_valid = 2'b00;
            tick();
            chk($sformatf("arb_rr_gap_%0d", t), rv_rr, 0);
            chk($sformatf("arb_rr_idle_%0d", t), busy_rr, 0);
        end

        // stuck waitrequest: the timeout build aborts after eight bus cycles
        set_req(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
        req_valid   = 2'b01;
        waitrequest = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("to_read_%0d", k), bus_rr.read, 1);
            chk($sformatf("to_rv_%0d", k),   rv_rr, 0);
        end
        tick();
        chk("to_read_off", bus_rr.read, 0);
        chk("to_rv",      rv_rr, 2'b01);
        chk("to_err",     er_rr, 1);
        chk("to_rdata",   rd_rr, 0);
        chk("to_fx_read", bus_fx.read, 1);
        waitrequest = 1'b0;
        readdata    = 32'h0BAD_F00D;
        tick();
        chk("to_rv_off",  rv_rr, 0);
        chk("to_err_off", er_rr, 0);
        chk("to_fx_rv",   rv_fx, 2'b01);
        chk("to_fx_err",  er_fx, 0);
        chk("to_fx_rdata", rd_fx, 32'h0BAD_F00D);
        req_valid = 2'b00;
        tick();
        set_req(0, 1'b1, 32'h0000_0080, 32'hA5A5_A5A5, 4'hF);
        req_valid = 2'b01;
        tick();
        chk("post_to_write", bus_rr.write, 1);
        chk("post_to_addr",  bus_rr.address, 32'h80);
        tick();
        chk("post_to_rv",  rv_rr, 2'b01);
        chk("post_to_err", er_rr, 0);
        req_valid = 2'b00;
        tick();

        // zero byte-enable write: no strobe, completes without touching the bus
        set_req(1, 1'b1, 32'h0000_0050, 32'hFFFF_FFFF, 4'b0000);
        req_valid = 2'b10;
        tick();
        chk("zbe_rv",    rv_rr, 2'b10);
        chk("zbe_write", bus_rr.write, 0);
        chk("zbe_read",  bus_rr.read, 0);
        chk("zbe_busy",  busy_rr, 1);
        chk("zbe_err",   er_rr, 0);
        chk("zbe_fx_write", bus_fx.write, 0);
        req_valid = 2'b00;
        tick();
        chk("zbe_rv_off", rv_rr, 0);
        chk("zbe_idle",   busy_rr, 0);

        // reset while stalled in BUS, then confirm the round-robin pointer restarted at 0
        set_req(0, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        req_valid   = 2'b01;
        waitrequest = 1'b1;
        tick();
        chk("mrst_read_pre", bus_rr.read, 1);
        reset     = 1'b1;
        req_valid = 2'b00;
        tick();
        chk("mrst_read",  bus_rr.read, 0);
        chk("mrst_busy",  busy_rr, 0);
        chk("mrst_rv",    rv_rr, 0);
        chk("mrst_fx_busy", busy_fx, 0);
        tick();
        chk("mrst_rv2",   rv_rr, 0);
        reset       = 1'b0;
        waitrequest = 1'b0;
        req_valid   = 2'b11;
        tick();
        chk("mrst_ptr_addr", bus_rr.address, 32'h300);
        chk("mrst_ptr_read", bus_rr.read, 1);
        tick();
        chk("mrst_ptr_rv", rv_rr, 2'b01);
        req_valid = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_master_arbiter.md
Name: avalon_master_arbiter

Overview:
- Parametrised Avalon-MM bus master front-end that arbitrates NUM_PORTS internal requesters onto one Avalon master port.
- Typical requesters: instruction fetch, data load/store and a debug port.
- Successor to the single-requester CPU bus interface; adds configurable channel count, widths, fixed or round-robin arbitration, and waitrequest timeout with error response.
- One transaction outstanding at a time.

Parameters:
- NUM_PORTS, 2: number of requester channels (1..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width, multiple of 8.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 0: maximum BUS-state cycles with waitrequest high before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  NUM_PORTS  per-port request; held high until resp_valid for that port.
- req_write  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_W  packed byte addresses, port i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  packed write data.
- req_be  in  NUM_PORTS*DATA_W/8  packed byte enables.
- resp_valid  out  NUM_PORTS  one-cycle completion pulse to the granted port.
- resp_rdata  out  DATA_W  read data; valid while resp_valid is high.
- resp_error  out  1  high with resp_valid on timeout abort.
- busy  out  1  high in any state other than IDLE.
- address  out  ADDR_W  Avalon address; low log2(DATA_W/8) bits forced to 0.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- waitrequest  in  1  Avalon waitrequest.
- writedata  out  DATA_W  Avalon write data.
- byteenable  out  DATA_W/8  Avalon byte enables.
- readdata  in  DATA_W  Avalon read data; sampled when read is high and waitrequest is low.

Behaviour:
- Reset values (clocked reset):
  - state = IDLE.
  - read, write, resp_valid, resp_error = 0.
  - address, writedata, byteenable, resp_rdata = 0.
  - Round-robin pointer = 0; timeout counter = 0.
- Reset mid-transaction: bus strobes drop at the next edge, no resp_valid is issued, and the in-flight request is discarded.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - If any req_valid is high, select a winner:
    - Fixed mode: lowest set index.
    - Round-robin mode: first set index at or after rr_ptr, wrapping modulo NUM_PORTS.
  - Latch the winner's addr, wdata, be, write flag and grant index.
  - rr_ptr <= grant+1, wrapping to 0 at NUM_PORTS.
  - Next state is BUS. read/write are asserted from BUS entry (registered), so the first bus cycle is one cycle after the request is seen.
  - Zero-byteenable exception: if the winner is a write with be == 0, skip BUS and go straight to DONE. No bus strobe is issued.
- BUS:
  - address, writedata, byteenable and read/write are held stable while waitrequest = 1.
  - When waitrequest = 0:
    - Deassert strobes at the edge.
    - If the transaction is a read, resp_rdata <= readdata.
    - Go to DONE.
  - Timeout counter:
    - Increments each BUS cycle with waitrequest = 1.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT: deassert strobes, set resp_error, resp_rdata <= 0, go to DONE.
    - Clears on BUS entry.
- DONE:
  - resp_valid[grant] = 1 for exactly one cycle; all other bits are 0.
  - Next state is IDLE.
  - The requester must drop req_valid or present a new request by the next edge. Arbitration never occurs in DONE, so a completed request is never re-granted.
- Latency: minimum 3 cycles from req_valid to resp_valid (waitrequest low on the first bus cycle); each extra waitrequest cycle adds 1.
- Simultaneous requests: losing ports wait with req_valid held, and are not starved in round-robin mode.
- Request changes on the granted port after grant are ignored; the latched values are used.
- resp_error is 0 on every non-timeout completion.
- read and write are never both high.
- NUM_PORTS = 1: the arbiter degenerates to a pass-through, with the same timing.

Decomposition:
- Shared package avalon_pkg:
  - state enum arb_state_t {IDLE, BUS, DONE}.
  - ARB_FIXED / ARB_RR constants.
  - A helper function computing byte-lane count from DATA_W.
- Sub-module rr_arbiter (NUM_PORTS, ARB_MODE): combinational winner select from the request vector and rr_ptr. The owning FSM holds rr_ptr.

Test Plan:
- Single read, port 0, addr 0x0000_1004, waitrequest low immediately, readdata 0xDEADBEEF -> address 0x1004, read high for 1 cycle, resp_valid = 01 with resp_rdata 0xDEADBEEF 3 cycles after request.
- Write, port 1, addr 0x0000_0013, wdata 0x1234_5678, be 0100, waitrequest high for 4 cycles -> address 0x10, byteenable 0100 and writedata stable for 5 cycles, write high throughout, resp_valid = 10 at cycle 7.
- Ports 0 and 1 request continuously, ARB_MODE = 1 -> grants alternate 0,1,0,1; with ARB_MODE = 0 -> port 0 always wins while held.
- TIMEOUT = 8, waitrequest stuck high -> read drops after 8 BUS cycles, resp_valid with resp_error = 1 and resp_rdata = 0; the next transaction completes normally with resp_error = 0.
- Write with be = 0000 -> no read/write strobe ever asserted, resp_valid 2 cycles after request.
- Reset asserted during BUS with waitrequest high -> read = 0, busy = 0 next cycle, no resp_valid, rr_ptr = 0.
